// File: rtl/alu_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_queue
//  Purpose  : Issue stage wrapped around a purely combinational 32-bit ALU.
//             Requests are buffered in a FIFO and decoded into the ALU
//             control word when they are popped. Operands are held in an
//             issue register that feeds the ALU. The ALU result and flags
//             are captured in a tagged result register behind a
//             valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [2:0]                 req_op_i,
    input  logic [31:0]                req_src1_i,
    input  logic [31:0]                req_src2_i,
    input  logic [TAG_W-1:0]           req_tag_i,
    output logic                       alu_rst_n_o,
    output logic [31:0]                alu_src1_o,
    output logic [31:0]                alu_src2_o,
    output logic [3:0]                 alu_ctrl_o,
    input  logic [31:0]                alu_result_i,
    input  logic                       alu_zero_i,
    input  logic                       alu_cout_i,
    input  logic                       alu_ovf_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [31:0]                out_result_o,
    output logic [2:0]                 out_flags_o,
    output logic                       out_err_o,
    output logic [TAG_W-1:0]           out_tag_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_LVL_W = $clog2(DEPTH) + 1;
    localparam logic [c_LVL_W-1:0] c_FULL  = c_LVL_W'(DEPTH);
    localparam logic [c_LVL_W-1:0] c_ONE   = c_LVL_W'(1);

    // Returns {err, Ainvert, Binvert, op[1:0]}; illegal opcodes fall back to ADD.
    function automatic logic [4:0] f_decode(input logic [2:0] op);
        logic [4:0] v;
        case (op)
            3'd0:    v = 5'b0_0000;  // AND
            3'd1:    v = 5'b0_0001;  // OR
            3'd2:    v = 5'b0_0010;  // ADD
            3'd3:    v = 5'b0_0110;  // SUB
            3'd4:    v = 5'b0_0111;  // SLT
            3'd5:    v = 5'b0_1100;  // NOR
            default: v = 5'b1_0010;  // illegal -> ADD with error
        endcase
        return v;
    endfunction

    // FIFO storage; the opcode is kept raw and decoded at pop time
    logic [2:0]         r_mem_op   [DEPTH];
    logic [31:0]        r_mem_src1 [DEPTH];
    logic [31:0]        r_mem_src2 [DEPTH];
    logic [TAG_W-1:0]   r_mem_tag  [DEPTH];

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;

    logic               r_iss_valid;
    logic [31:0]        r_iss_src1;
    logic [31:0]        r_iss_src2;
    logic [3:0]         r_iss_ctrl;
    logic [TAG_W-1:0]   r_iss_tag;
    logic               r_iss_err;

    logic               r_out_valid;
    logic [31:0]        r_out_result;
    logic [2:0]         r_out_flags;
    logic               r_out_err;
    logic [TAG_W-1:0]   r_out_tag;

    logic               w_push;
    logic               w_pop;
    logic               w_res_load;
    logic               w_iss_adv;
    logic [4:0]         w_head_dec;

    // Handshake and pipeline advance conditions
    always_comb begin
        w_push     = req_valid_i && (r_level != c_FULL);
        w_res_load = r_iss_valid && (!r_out_valid || out_ready_i);
        w_iss_adv  = !r_iss_valid || w_res_load;
        w_pop      = w_iss_adv && (r_level != '0);
        w_head_dec = f_decode(r_mem_op[r_rd_ptr]);
    end

    // FIFO payload write; contents need no reset because the level gates reads
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_op[r_wr_ptr]   <= req_op_i;
            r_mem_src1[r_wr_ptr] <= req_src1_i;
            r_mem_src2[r_wr_ptr] <= req_src2_i;
            r_mem_tag[r_wr_ptr]  <= req_tag_i;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + c_ONE;
            else if (w_pop && !w_push) r_level <= r_level - c_ONE;
        end
    end

    // Issue register: takes the FIFO head whenever it is free to advance
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_iss_valid <= 1'b0;
            r_iss_src1  <= '0;
            r_iss_src2  <= '0;
            r_iss_ctrl  <= 4'b0000;
            r_iss_tag   <= '0;
            r_iss_err   <= 1'b0;
        end else if (w_iss_adv) begin
            if (w_pop) begin
                r_iss_valid <= 1'b1;
                r_iss_src1  <= r_mem_src1[r_rd_ptr];
                r_iss_src2  <= r_mem_src2[r_rd_ptr];
                r_iss_ctrl  <= w_head_dec[3:0];
                r_iss_tag   <= r_mem_tag[r_rd_ptr];
                r_iss_err   <= w_head_dec[4];
            end else begin
                r_iss_valid <= 1'b0;
            end
        end
    end

    // Result register: captures the ALU output unmodified, holds while stalled
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_flags  <= '0;
            r_out_err    <= 1'b0;
            r_out_tag    <= '0;
        end else if (w_res_load) begin
            r_out_valid  <= 1'b1;
            r_out_result <= alu_result_i;
            r_out_flags  <= {alu_zero_i, alu_cout_i, alu_ovf_i};
            r_out_err    <= r_iss_err;
            r_out_tag    <= r_iss_tag;
        end else if (out_ready_i) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign req_ready_o  = (r_level != c_FULL);
    assign alu_rst_n_o  = ~rst_i;
    assign alu_src1_o   = r_iss_src1;
    assign alu_src2_o   = r_iss_src2;
    assign alu_ctrl_o   = r_iss_ctrl;
    assign out_valid_o  = r_out_valid;
    assign out_result_o = r_out_result;
    assign out_flags_o  = r_out_flags;
    assign out_err_o    = r_out_err;
    assign out_tag_o    = r_out_tag;
    assign level_o      = r_level;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_queue
//  Purpose  : Directed self-checking bench for alu_issue_queue, including a
//             behavioural model of the combinational ALU it feeds.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   req_valid_i;
    logic                   req_ready_o;
    logic [2:0]             req_op_i;
    logic [31:0]            req_src1_i;
    logic [31:0]            req_src2_i;
    logic [TAG_W-1:0]       req_tag_i;
    logic                   alu_rst_n_o;
    logic [31:0]            alu_src1_o;
    logic [31:0]            alu_src2_o;
    logic [3:0]             alu_ctrl_o;
    logic [31:0]            alu_result_i;
    logic                   alu_zero_i;
    logic                   alu_cout_i;
    logic                   alu_ovf_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [31:0]            out_result_o;
    logic [2:0]             out_flags_o;
    logic                   out_err_o;
    logic [TAG_W-1:0]       out_tag_o;
    logic [$clog2(DEPTH):0] level_o;

    int errors = 0;
    int checks = 0;

    alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_src1_i   (req_src1_i),
        .req_src2_i   (req_src2_i),
        .req_tag_i    (req_tag_i),
        .alu_rst_n_o  (alu_rst_n_o),
        .alu_src1_o   (alu_src1_o),
        .alu_src2_o   (alu_src2_o),
        .alu_ctrl_o   (alu_ctrl_o),
        .alu_result_i (alu_result_i),
        .alu_zero_i   (alu_zero_i),
        .alu_cout_i   (alu_cout_i),
        .alu_ovf_i    (alu_ovf_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_result_o (out_result_o),
        .out_flags_o  (out_flags_o),
        .out_err_o    (out_err_o),
        .out_tag_o    (out_tag_o),
        .level_o      (level_o)
    );

    always #5 clk_i = ~clk_i;

    // Combinational ALU model driven by the issue register
    always_comb begin
        logic [32:0] w_sum;
        logic [32:0] w_dif;
        w_sum        = {1'b0, alu_src1_o} + {1'b0, alu_src2_o};
        w_dif        = {1'b0, alu_src1_o} + {1'b0, ~alu_src2_o} + 33'd1;
        alu_result_i = 32'd0;
        alu_cout_i   = 1'b0;
        alu_ovf_i    = 1'b0;
        case (alu_ctrl_o)
            4'b0000: alu_result_i = alu_src1_o & alu_src2_o;
            4'b0001: alu_result_i = alu_src1_o | alu_src2_o;
            4'b0010: begin
                alu_result_i = w_sum[31:0];
                alu_cout_i   = w_sum[32];
                alu_ovf_i    = (alu_src1_o[31] == alu_src2_o[31]) && (w_sum[31] != alu_src1_o[31]);
            end
            4'b0110: begin
                alu_result_i = w_dif[31:0];
                alu_cout_i   = w_dif[32];
                alu_ovf_i    = (alu_src1_o[31] != alu_src2_o[31]) && (w_dif[31] != alu_src1_o[31]);
            end
            4'b0111: alu_result_i = {31'd0, ($signed(alu_src1_o) < $signed(alu_src2_o))};
            4'b1100: alu_result_i = ~(alu_src1_o | alu_src2_o);
            default: alu_result_i = 32'd0;
        endcase
        alu_zero_i = (alu_result_i == 32'd0);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] t);
        req_valid_i = v;
        req_op_i    = op;
        req_src1_i  = a;
        req_src2_i  = b;
        req_tag_i   = t;
    endtask

    initial begin
        rst_i       = 1'b1;
        out_ready_i = 1'b1;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 4'd0);
        step();
        step();
        // Reset state
        check("rst_alu_rst_n", 64'(alu_rst_n_o), 64'd0);
        check("rst_level", 64'(level_o), 64'd0);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_ctrl", 64'(alu_ctrl_o), 64'd0);
        check("rst_src1", 64'(alu_src1_o), 64'd0);
        check("rst_out_fields", {out_result_o, 25'd0, out_flags_o, out_err_o, out_tag_o}, 64'd0);
        check("rst_ready", 64'(req_ready_o), 64'd1);
        rst_i = 1'b0;
        #1;
        check("alu_rst_n_release", 64'(alu_rst_n_o), 64'd1);

        // Single ADD: 5 + 3, tag 1
        drive(1'b1, 3'd2, 32'd5, 32'd3, 4'd1);
        step();                                   // accepted in cycle 0
        drive(1'b0, 3'd0, 32'd0, 32'd0, 4'd0);
        check("add_level1", 64'(level_o), 64'd1);
        check("add_out_valid_c1", 64'(out_valid_o), 64'd0);
        step();                                   // cycle 2
        check("add_ctrl", 64'(alu_ctrl_o), 64'h2);
        check("add_src1", 64'(alu_src1_o), 64'd5);
        check("add_out_valid_c2", 64'(out_valid_o), 64'd0);
        step();                                   // cycle 3
        check("add_out_valid", 64'(out_valid_o), 64'd1);
        check("add_result", 64'(out_result_o), 64'd8);
        check("add_flags", 64'(out_flags_o), 64'd0);
        check("add_err", 64'(out_err_o), 64'd0);
        check("add_tag", 64'(out_tag_o), 64'd1);
        step();
        check("add_drain", 64'(out_valid_o), 64'd0);

        // SUB 5-5 then SLT -1 < 1, back to back
        drive(1'b1, 3'd3, 32'd5, 32'd5, 4'd2);
        step();
        drive(1'b1, 3'd4, 32'hFFFF_FFFF, 32'd1, 4'd3);
        step();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 4'd0);
        check("sub_ctrl", 64'(alu_ctrl_o), 64'h6);
        check("bb_level", 64'(level_o), 64'd1);
        step();
        check("slt_ctrl", 64'(alu_ctrl_o), 64'h7);
        check("sub_valid", 64'(out_valid_o), 64'd1);
        check("sub_result", 64'(out_result_o), 64'd0);
        check("sub_zero", 64'(out_flags_o[2]), 64'd1);
        check("sub_tag", 64'(out_tag_o), 64'd2);
        step();
        check("slt_valid", 64'(out_valid_o), 64'd1);
        check("slt_result", 64'(out_result_o), 64'd1);
        check("slt_tag", 64'(out_tag_o), 64'd3);
        step();
        check("slt_drain", 64'(out_valid_o), 64'd0);

        // Stall: push 6 ADDs (src1=i, src2=10) with the consumer blocked
        out_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 3'd2, 32'(i), 32'd10, 4'(i));
            step();
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0, 4'd0);
        check("stall_level_full", 64'(level_o), 64'd4);
        check("stall_ready_low", 64'(req_ready_o), 64'd0);
        check("stall_valid", 64'(out_valid_o), 64'd1);
        check("stall_tag0", 64'(out_tag_o), 64'd0);
        check("stall_result0", 64'(out_result_o), 64'd10);
        check("stall_issue_src1", 64'(alu_src1_o), 64'd1);
        // Push attempt while full must be ignored
        drive(1'b1, 3'd2, 32'd99, 32'd0, 4'd9);
        step();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 4'd0);
        step();
        check("stall_level_hold", 64'(level_o), 64'd4);
        check("stall_hold_tag", 64'(out_tag_o), 64'd0);
        check("stall_hold_result", 64'(out_result_o), 64'd10);
        check("stall_hold_issue", 64'(alu_src1_o), 64'd1);
        out_ready_i = 1'b1;
        for (int i = 1; i < 6; i++) begin
            step();
            check($sformatf("drain_valid_%0d", i), 64'(out_valid_o), 64'd1);
            check($sformatf("drain_tag_%0d", i), 64'(out_tag_o), 64'(i));
            check($sformatf("drain_result_%0d", i), 64'(out_result_o), 64'(i + 10));
        end
        step();
        check("drain_done_valid", 64'(out_valid_o), 64'd0);
        check("drain_done_level", 64'(level_o), 64'd0);

        // Illegal opcode 7: 2 + 2 with error flag
        drive(1'b1, 3'd7, 32'd2, 32'd2, 4'd7);
        step();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 4'd0);
        step();
        check("ill_ctrl", 64'(alu_ctrl_o), 64'h2);
        step();
        check("ill_valid", 64'(out_valid_o), 64'd1);
        check("ill_result", 64'(out_result_o), 64'd4);
        check("ill_err", 64'(out_err_o), 64'd1);
        check("ill_tag", 64'(out_tag_o), 64'd7);
        step();

        // Signed overflow: 7FFFFFFF + 1
        drive(1'b1, 3'd2, 32'h7FFF_FFFF, 32'd1, 4'd4);
        step();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 4'd0);
        step();
        step();
        check("ovf_result", 64'(out_result_o), 64'h8000_0000);
        check("ovf_flags", 64'(out_flags_o), 64'b001);
        check("ovf_err", 64'(out_err_o), 64'd0);
        step();

        // Reset mid-operation with 3 queued and a result pending
        out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'd1, 32'(i), 32'd0, 4'(i + 8));
            step();
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0, 4'd0);
        check("pre_rst_level", 64'(level_o), 64'd3);
        check("pre_rst_valid", 64'(out_valid_o), 64'd1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("mid_rst_level", 64'(level_o), 64'd0);
        check("mid_rst_valid", 64'(out_valid_o), 64'd0);
        check("mid_rst_ctrl", 64'(alu_ctrl_o), 64'd0);
        out_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("post_rst_quiet_%0d", i), 64'(out_valid_o), 64'd0);
        end
        check("post_rst_level", 64'(level_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
